// File: rtl/mfcc_coeff_reader.sv
// mfcc_coeff_reader
// Captures a parallel 13-coefficient MFCC frame on each rising edge of
// mfcc_done and streams it out one coefficient per valid/ready transfer.
// One extra frame can wait in a pending slot. A frame that arrives while both
// slots are occupied is dropped and sets the sticky overflow flag.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   mfcc_done            : frame-complete level from the MFCC engine
//   mfcc_in_0..12 [17:0] : parallel unsigned coefficients
//   coeff_ready          : downstream accepts the current word
//   clear_ovf            : synchronous clear of overflow
//   coeff_data [17:0]    : streamed coefficient
//   coeff_idx  [3:0]     : index of coeff_data
//   coeff_valid          : coeff_data / coeff_idx valid
//   coeff_last           : final word of the frame (index 12)
//   busy                 : streaming or pending slot occupied
//   overflow             : sticky, a frame was dropped
//   frame_count [15:0]   : frames fully streamed, wrapping
//
// Configuration
//   MFCC_DROP_C0_EN : when defined, coefficient 0 is skipped and each frame
//                     streams indices 1..12 only.
module mfcc_coeff_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        mfcc_done,
    input  logic [17:0] mfcc_in_0,
    input  logic [17:0] mfcc_in_1,
    input  logic [17:0] mfcc_in_2,
    input  logic [17:0] mfcc_in_3,
    input  logic [17:0] mfcc_in_4,
    input  logic [17:0] mfcc_in_5,
    input  logic [17:0] mfcc_in_6,
    input  logic [17:0] mfcc_in_7,
    input  logic [17:0] mfcc_in_8,
    input  logic [17:0] mfcc_in_9,
    input  logic [17:0] mfcc_in_10,
    input  logic [17:0] mfcc_in_11,
    input  logic [17:0] mfcc_in_12,
    input  logic        coeff_ready,
    input  logic        clear_ovf,
    output logic [17:0] coeff_data,
    output logic [3:0]  coeff_idx,
    output logic        coeff_valid,
    output logic        coeff_last,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_count
);

    localparam int unsigned CW = 18;
    localparam int unsigned NC = 13;
    localparam int unsigned IW = 4;
    localparam int unsigned FW = 16;

    localparam logic [IW-1:0] LAST_IDX = IW'(12);
`ifdef MFCC_DROP_C0_EN
    localparam logic [IW-1:0] FIRST_IDX = IW'(1);
`else
    localparam logic [IW-1:0] FIRST_IDX = IW'(0);
`endif

    typedef logic [CW-1:0] coeff_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Parallel inputs gathered into an indexable array
    coeff_t in_c [NC];

    assign in_c[0]  = mfcc_in_0;
    assign in_c[1]  = mfcc_in_1;
    assign in_c[2]  = mfcc_in_2;
    assign in_c[3]  = mfcc_in_3;
    assign in_c[4]  = mfcc_in_4;
    assign in_c[5]  = mfcc_in_5;
    assign in_c[6]  = mfcc_in_6;
    assign in_c[7]  = mfcc_in_7;
    assign in_c[8]  = mfcc_in_8;
    assign in_c[9]  = mfcc_in_9;
    assign in_c[10] = mfcc_in_10;
    assign in_c[11] = mfcc_in_11;
    assign in_c[12] = mfcc_in_12;

    state_t          state_q, state_d;
    coeff_t          act_q  [NC];
    coeff_t          act_d  [NC];
    coeff_t          pend_q [NC];
    coeff_t          pend_d [NC];
    logic            pend_full_q, pend_full_d;
    logic            done_q;
    logic [IW-1:0]   idx_q, idx_d;
    coeff_t          data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;

    logic            cap_ev_c;
    logic            xfer_c;
    logic            last_xfer_c;
    logic            ovf_set_c;
    logic [IW-1:0]   idx_inc_c;

    // Rising edge of mfcc_done; done_q resets to 0 so a level held through
    // reset deassertion still produces one event
    assign cap_ev_c    = mfcc_done & ~done_q;
    assign xfer_c      = valid_q & coeff_ready;
    assign last_xfer_c = xfer_c & last_q;
    assign idx_inc_c   = idx_q + IW'(1);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            act_q       <= '{default: '0};
            pend_q      <= '{default: '0};
            pend_full_q <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            done_q      <= mfcc_done;
            idx_q       <= idx_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // Next-state: capture, streaming advance and pending-slot handoff
    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        fcnt_d      = fcnt_q;
        ovf_set_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cap_ev_c) begin
                    act_d   = in_c;
                    state_d = STREAM;
                    idx_d   = FIRST_IDX;
                    data_d  = in_c[FIRST_IDX];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end

            STREAM: begin
                if (last_xfer_c) begin
                    fcnt_d  = fcnt_q + FW'(1);
                    idx_d   = FIRST_IDX;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    if (pend_full_q) begin
                        // Pending frame follows with no bubble; a simultaneous
                        // capture refills the slot just vacated
                        act_d  = pend_q;
                        data_d = pend_q[FIRST_IDX];
                        if (cap_ev_c) begin
                            pend_d = in_c;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (cap_ev_c) begin
                        act_d  = in_c;
                        data_d = in_c[FIRST_IDX];
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        data_d  = '0;
                    end
                end else begin
                    if (xfer_c) begin
                        idx_d  = idx_inc_c;
                        data_d = act_q[idx_inc_c];
                        last_d = (idx_inc_c == LAST_IDX);
                    end
                    if (cap_ev_c) begin
                        if (!pend_full_q) begin
                            pend_d      = in_c;
                            pend_full_d = 1'b1;
                        end else begin
                            ovf_set_c = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A new drop wins over a same-cycle clear
        ovf_d  = (ovf_q & ~clear_ovf) | ovf_set_c;
        busy_d = (state_d == STREAM) | pend_full_d;
    end

    assign coeff_data  = data_q;
    assign coeff_idx   = idx_q;
    assign coeff_valid = valid_q;
    assign coeff_last  = last_q;
    assign busy        = busy_q;
    assign overflow    = ovf_q;
    assign frame_count = fcnt_q;

endmodule
